// File: rtl/huarong_move_sequencer.sv
// huarong_move_sequencer
//   Sole source of move commands for the 3x3 sliding-tile datapath. Player key
//   edges become blank-relative moves. A start edge runs an LFSR-driven
//   scramble of SHUFFLE_MOVES legal, non-reversing random moves. A player move
//   that leaves the board solved raises gameover.
//
// Ports
//   R_clk_2M     system clock
//   I_reset      synchronous, active-high reset
//   I_start      level; a rising edge starts a shuffle
//   I_up/down/left/right  debounced key levels
//   I_board      board, cell k (1..9, row-major) at [4k-1:4k-4]; 0 = blank
//   O_up/down/left/right  one-cycle move pulses (at most one high)
//   O_num_index  cell of the tile being moved; 0 when no pulse is issued
//   O_busy       high while a move is in flight or a shuffle is running
//   O_gameover   board solved by a player move
//   O_moves      player move count, saturating
//
// Handshake: there is no backpressure. A pulse with its index is held for
// exactly one cycle, and the datapath applies it on that cycle's closing edge.
// The board is sampled again only from the following cycle.
module huarong_move_sequencer #(
  parameter int          SHUFFLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        R_clk_2M,
  input  logic        I_reset,
  input  logic        I_start,
  input  logic        I_up,
  input  logic        I_down,
  input  logic        I_left,
  input  logic        I_right,
  input  logic [35:0] I_board,
  output logic        O_up,
  output logic        O_down,
  output logic        O_left,
  output logic        O_right,
  output logic [3:0]  O_num_index,
  output logic        O_busy,
  output logic        O_gameover,
  output logic [15:0] O_moves
);

  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [7:0]  SHUF_N = 8'(SHUFFLE_MOVES);

  // Direction codes; xor with 1 gives the reverse direction.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    IDLE, SHUF_PICK, SHUF_ISSUE, SHUF_SETTLE, PLAY, ISSUE, SETTLE, DONE
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [7:0]  shuf_cnt;
  logic [1:0]  last_dir;
  logic        last_valid;
  logic [3:0]  key_prev;
  logic        start_prev;

  // Returns {legal, tile_cell} for moving toward blank cell b in direction d.
  function automatic logic [4:0] move_of(input logic [3:0] b, input logic [1:0] d);
    logic       ok;
    logic [3:0] t;
    case (d)
      DIR_UP:   begin ok = (b <= 4'd6); t = b + 4'd3; end
      DIR_DOWN: begin ok = (b >= 4'd4); t = b - 4'd3; end
      DIR_LEFT: begin ok = !(b == 4'd3 || b == 4'd6 || b == 4'd9); t = b + 4'd1; end
      default:  begin ok = !(b == 4'd1 || b == 4'd4 || b == 4'd7); t = b - 4'd1; end
    endcase
    return {ok, t};
  endfunction

  // Lowest-numbered empty cell wins if the board holds several zeros.
  logic [3:0] blank;
  logic       blank_ok;
  always_comb begin
    blank    = 4'd0;
    blank_ok = 1'b0;
    for (int k = 9; k >= 1; k--) begin
      if (I_board[4*k-1 -: 4] == 4'd0) begin
        blank    = 4'(k);
        blank_ok = 1'b1;
      end
    end
  end

  logic solved;
  always_comb begin
    solved = (I_board[35:32] == 4'd0);
    for (int k = 1; k <= 8; k++) begin
      if (I_board[4*k-1 -: 4] != 4'(k)) solved = 1'b0;
    end
  end

  // Key edges, bit 3 = up .. bit 0 = right; the highest set bit wins.
  logic [3:0] key_lvl, key_edge;
  logic [1:0] key_dir;
  logic [4:0] key_move, rnd_move;
  logic       key_go, rnd_go, start_edge;
  always_comb begin
    key_lvl    = {I_up, I_down, I_left, I_right};
    key_edge   = key_lvl & ~key_prev;
    key_dir    = key_edge[3] ? DIR_UP :
                 key_edge[2] ? DIR_DOWN :
                 key_edge[1] ? DIR_LEFT : DIR_RIGHT;
    key_move   = move_of(blank, key_dir);
    key_go     = (|key_edge) && blank_ok && key_move[4] && !O_gameover;
    rnd_move   = move_of(blank, lfsr[1:0]);
    rnd_go     = blank_ok && rnd_move[4] &&
                 !(last_valid && (lfsr[1:0] == (last_dir ^ 2'b01)));
    start_edge = I_start && !start_prev;
  end

  always_ff @(posedge R_clk_2M) begin
    if (I_reset) begin
      state       <= IDLE;
      lfsr        <= SEED;
      shuf_cnt    <= 8'd0;
      last_dir    <= DIR_UP;
      last_valid  <= 1'b0;
      key_prev    <= key_lvl;
      start_prev  <= I_start;
      O_up        <= 1'b0;
      O_down      <= 1'b0;
      O_left      <= 1'b0;
      O_right     <= 1'b0;
      O_num_index <= 4'd0;
      O_busy      <= 1'b0;
      O_gameover  <= 1'b0;
      O_moves     <= 16'd0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      key_prev   <= key_lvl;
      start_prev <= I_start;
      // Pulses and index live for exactly one cycle unless set below.
      O_up        <= 1'b0;
      O_down      <= 1'b0;
      O_left      <= 1'b0;
      O_right     <= 1'b0;
      O_num_index <= 4'd0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= SHUF_PICK;
            O_busy <= 1'b1;
          end
        end
        SHUF_PICK: begin
          if (rnd_go) begin
            {O_up, O_down, O_left, O_right} <= 4'b1000 >> lfsr[1:0];
            O_num_index <= rnd_move[3:0];
            last_dir    <= lfsr[1:0];
            last_valid  <= 1'b1;
            state       <= SHUF_ISSUE;
          end
        end
        SHUF_ISSUE: begin
          shuf_cnt <= shuf_cnt + 8'd1;
          state    <= SHUF_SETTLE;
        end
        SHUF_SETTLE: begin
          if (shuf_cnt == SHUF_N) begin
            shuf_cnt <= 8'd0;
            O_busy   <= 1'b0;
            state    <= PLAY;
          end else begin
            state <= SHUF_PICK;
          end
        end
        PLAY: begin
          if (start_edge) begin
            O_busy <= 1'b1;
            state  <= SHUF_PICK;
          end else if (key_go) begin
            {O_up, O_down, O_left, O_right} <= 4'b1000 >> key_dir;
            O_num_index <= key_move[3:0];
            O_busy      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (O_moves != 16'hFFFF) O_moves <= O_moves + 16'd1;
          state <= SETTLE;
        end
        SETTLE: begin
          O_busy <= 1'b0;
          if (solved) begin
            O_gameover <= 1'b1;
            state      <= DONE;
          end else begin
            state <= PLAY;
          end
        end
        DONE: begin
          if (start_edge) begin
            O_gameover <= 1'b0;
            O_moves    <= 16'd0;
            O_busy     <= 1'b1;
            state      <= SHUF_PICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
